// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared constants for the ALU and the UART command sequencer that feeds it:
//   default widths, ALU opcode values and the sequencer state encoding.
//   No ports (package only).
// -----------------------------------------------------------------------------
package alu_pkg;

    // Default widths
    localparam int NB_DATA_DFLT = 8;
    localparam int NB_OP_DFLT   = 6;

    // ALU opcodes (MIPS funct-style encoding)
    localparam logic [NB_OP_DFLT-1:0] ADD = 6'b100000;
    localparam logic [NB_OP_DFLT-1:0] SUB = 6'b100010;
    localparam logic [NB_OP_DFLT-1:0] AND = 6'b100100;
    localparam logic [NB_OP_DFLT-1:0] OR  = 6'b100101;
    localparam logic [NB_OP_DFLT-1:0] XOR = 6'b100110;
    localparam logic [NB_OP_DFLT-1:0] SRA = 6'b000011;
    localparam logic [NB_OP_DFLT-1:0] SRL = 6'b000010;
    localparam logic [NB_OP_DFLT-1:0] NOR = 6'b100111;

    // Sequencer states
    localparam int          NB_STATE = 3;
    localparam logic [2:0]  GET_A    = 3'd0;
    localparam logic [2:0]  GET_B    = 3'd1;
    localparam logic [2:0]  GET_OP   = 3'd2;
    localparam logic [2:0]  EXEC     = 3'd3;
    localparam logic [2:0]  WAIT_TX  = 3'd4;
    localparam logic [2:0]  CARRY_TX = 3'd5;

endpackage : alu_pkg

// File: rtl/alu_uart_iface.sv
// -----------------------------------------------------------------------------
// alu_uart_iface
//   Sequencer between a UART RX/TX pair and a combinational ALU. Three received
//   bytes (operand A, operand B, opcode) are registered and presented to the
//   ALU; one cycle later the result is captured and handed to the UART TX with
//   a one-cycle start pulse, then the block waits for the TX done strobe.
//
//   Optional feature (macro ALU_UART_IFACE_CARRY_BYTE_EN):
//     defined   -> after the result byte, a second byte {0..0, carry} is sent.
//     undefined -> one byte per command, carry is not stored.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_rx_data    received byte, valid with i_rx_done
//   i_rx_done    one-cycle RX strobe
//   i_tx_done    one-cycle TX finished strobe
//   i_alu_res    ALU result
//   i_alu_carry  ALU carry/borrow
//   o_dato_a     registered operand A
//   o_dato_b     registered operand B
//   o_op         registered opcode (low NB_OP bits of third byte)
//   o_tx_data    byte to transmit, stable from o_tx_start until i_tx_done
//   o_tx_start   one-cycle TX start pulse
//   o_busy       low only while waiting for operand A
// -----------------------------------------------------------------------------
module alu_uart_iface
    import alu_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DFLT,
    parameter int NB_OP   = NB_OP_DFLT
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_res,
    input  logic               i_alu_carry,
    output logic [NB_DATA-1:0] o_dato_a,
    output logic [NB_DATA-1:0] o_dato_b,
    output logic [NB_OP-1:0]   o_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy
);

    logic [NB_STATE-1:0] state;

`ifdef ALU_UART_IFACE_CARRY_BYTE_EN
    logic carry_q;
`else
    // Carry is not reported in this build; the input is intentionally sunk.
    logic unused_carry;
    assign unused_carry = i_alu_carry;
`endif

    // o_busy is registered alongside the state so it is high exactly when the
    // next state is anything other than GET_A.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= GET_A;
            o_dato_a   <= '0;
            o_dato_b   <= '0;
            o_op       <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
`ifdef ALU_UART_IFACE_CARRY_BYTE_EN
            carry_q    <= 1'b0;
`endif
        end else begin
            // Start is a single-cycle pulse; only the launching edges raise it.
            o_tx_start <= 1'b0;
            case (state)
                GET_A: begin
                    if (i_rx_done) begin
                        o_dato_a <= i_rx_data;
                        state    <= GET_B;
                        o_busy   <= 1'b1;
                    end
                end
                GET_B: begin
                    if (i_rx_done) begin
                        o_dato_b <= i_rx_data;
                        state    <= GET_OP;
                    end
                end
                GET_OP: begin
                    if (i_rx_done) begin
                        // Upper bits of the opcode byte are discarded.
                        o_op  <= i_rx_data[NB_OP-1:0];
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands have been stable on the ALU for a full cycle.
                    o_tx_data  <= i_alu_res;
                    o_tx_start <= 1'b1;
                    state      <= WAIT_TX;
`ifdef ALU_UART_IFACE_CARRY_BYTE_EN
                    carry_q    <= i_alu_carry;
`endif
                end
                WAIT_TX: begin
                    // RX strobes are dropped here; tx_done wins a same-cycle tie.
                    if (i_tx_done) begin
`ifdef ALU_UART_IFACE_CARRY_BYTE_EN
                        o_tx_data  <= {{(NB_DATA-1){1'b0}}, carry_q};
                        o_tx_start <= 1'b1;
                        state      <= CARRY_TX;
`else
                        state      <= GET_A;
                        o_busy     <= 1'b0;
`endif
                    end
                end
`ifdef ALU_UART_IFACE_CARRY_BYTE_EN
                CARRY_TX: begin
                    if (i_tx_done) begin
                        state  <= GET_A;
                        o_busy <= 1'b0;
                    end
                end
`endif
                default: begin
                    state  <= GET_A;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule : alu_uart_iface

// File: tb/tb_alu_uart_iface.sv
module tb_alu_uart_iface;
    import alu_pkg::*;

`ifdef ALU_UART_IFACE_CARRY_BYTE_EN
    localparam int NBYTES = 2;
`else
    localparam int NBYTES = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_done = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] alu_res;
    logic       alu_carry;
    logic [7:0] dato_a, dato_b, tx_data;
    logic [5:0] op;
    logic       tx_start, busy;

    always #5 clk = ~clk;

    alu_uart_iface #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rx_data(rx_data), .i_rx_done(rx_done), .i_tx_done(tx_done),
        .i_alu_res(alu_res), .i_alu_carry(alu_carry),
        .o_dato_a(dato_a), .o_dato_b(dato_b), .o_op(op),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy)
    );

    // Reference ALU: {carry, result}
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] o);
        logic [7:0] r;
        case (o)
            ADD: return {1'b0, a} + {1'b0, b};
            SUB: return {(a < b), 8'(a - b)};
            AND: return {1'b0, a & b};
            OR:  return {1'b0, a | b};
            XOR: return {1'b0, a ^ b};
            NOR: return {1'b0, ~(a | b)};
            SRA: begin r = 8'($signed(a) >>> b); return {1'b0, r}; end
            SRL: return {1'b0, a >> b};
            default: return 9'd0;
        endcase
    endfunction

    // The ALU sits beside the DUT, fed by its registered operands.
    logic [8:0] alu_out;
    always_comb begin
        alu_out   = alu_f(dato_a, dato_b, op);
        alu_res   = alu_out[7:0];
        alu_carry = alu_out[8];
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Monitor: every start pulse must match the next expected byte.
    logic prev_start = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && tx_start) begin
                check("start_1cyc", {31'd0, prev_start}, 32'd0);
                if (exp_q.size() == 0)
                    check("spurious_start", {31'd0, tx_start}, 32'd0);
                else
                    check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
            prev_start = tx_start;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic rx_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!tx_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!tx_start) check("start_timeout", {31'd0, tx_start}, 32'd1);
    endtask

    // mode 0: plain; 1: stray rx byte in WAIT_TX; 2: rx and tx_done same cycle
    task automatic finish_cmd(input int mode);
        logic [7:0] d;
        for (int k = 0; k < NBYTES; k++) begin
            wait_start();
            d = tx_data;
            if (k == 0 && mode == 1) begin
                rx_byte(8'hAA);
                check("busy_wait", {31'd0, busy}, 32'd1);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("tx_hold", {24'd0, tx_data}, {24'd0, d});
            if (k == 0 && mode == 2) begin
                rx_data = 8'hAA;
                rx_done = 1'b1;
            end
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            rx_done = 1'b0;
            if (k < NBYTES - 1) check("busy_mid", {31'd0, busy}, 32'd1);
        end
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] opb, input int mode, input int exp_first);
        logic [8:0] r;
        r = alu_f(a, b, opb[5:0]);
        exp_q.push_back(r[7:0]);
        if (NBYTES == 2) exp_q.push_back({7'd0, r[8]});
        rx_byte(a);
        rx_byte(b);
        rx_byte(opb);
        check("op_reg", {26'd0, op}, {26'd0, opb[5:0]});
        check("a_reg", {24'd0, dato_a}, {24'd0, a});
        check("b_reg", {24'd0, dato_b}, {24'd0, b});
        check("lat_n", {31'd0, tx_start}, 32'd0);
        @(negedge clk);
        check("lat_n1", {31'd0, tx_start}, 32'd1);
        if (exp_first >= 0) check("first_byte", {24'd0, tx_data}, exp_first);
        finish_cmd(mode);
        check("a_kept", {24'd0, dato_a}, {24'd0, a});
        check("op_kept", {26'd0, op}, {26'd0, opb[5:0]});
    endtask

    logic [5:0] ops [8];
    logic [7:0] ob;

    initial begin
        ops = '{ADD, SUB, AND, OR, XOR, SRA, SRL, NOR};
        @(negedge clk);
        @(negedge clk);
        check("rst_a", {24'd0, dato_a}, 32'd0);
        check("rst_b", {24'd0, dato_b}, 32'd0);
        check("rst_op", {26'd0, op}, 32'd0);
        check("rst_tx", {24'd0, tx_data}, 32'd0);
        check("rst_start", {31'd0, tx_start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // tx_done while idle is ignored
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
        check("idle_txdone_busy", {31'd0, busy}, 32'd0);

        send_cmd(8'h05, 8'h03, 8'h20, 0, 8'h08);
        send_cmd(8'h03, 8'h05, 8'h22, 0, 8'hFE);
        send_cmd(8'hF0, 8'h0F, 8'hE7, 0, 8'h00);
        check("nor_op", {26'd0, op}, 32'h27);
        send_cmd(8'h5A, 8'h11, 8'h20, 1, 8'h6B);
        send_cmd(8'h12, 8'h34, 8'h26, 0, 8'h26);

        // Reset while waiting for the opcode discards the command
        rx_byte(8'h11);
        rx_byte(8'h22);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_a", {24'd0, dato_a}, 32'd0);
        check("mid_rst_b", {24'd0, dato_b}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_nostart", {31'd0, tx_start}, 32'd0);
        end
        send_cmd(8'h01, 8'h01, 8'h25, 0, 8'h01);

        // Same-cycle rx + tx_done in WAIT_TX
        send_cmd(8'h80, 8'h01, 8'h03, 2, 8'hC0);
        send_cmd(8'h80, 8'h01, 8'h02, 0, 8'h40);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) ob = 8'($urandom);
            else ob = {2'($urandom), ops[$urandom_range(0, 7)]};
            send_cmd(8'($urandom), 8'($urandom), ob, int'($urandom_range(0, 2)), -1);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_uart_iface

// File: doc/alu_uart_iface.md
Name: alu_uart_iface

Overview:
- Sequencer between the UART receiver/transmitter and the combinational ALU.
- Collects three received bytes in order: operand A, operand B, opcode.
- Drives them to the ALU, registers the result, and hands it to the UART TX with a start/done handshake.
- Replaces the switch/button operand loading with a serial command protocol.

Parameters:
- NB_DATA, 8, width of operands, result and UART data bytes.
- NB_OP, 6, opcode width; taken from the low NB_OP bits of the third byte.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_rx_data  in  NB_DATA  received byte; valid when i_rx_done=1.
- i_rx_done  in  1  one-cycle strobe from UART RX.
- i_tx_done  in  1  one-cycle strobe from UART TX when a byte has finished sending.
- i_alu_res  in  NB_DATA  ALU result.
- i_alu_carry  in  1  ALU carry/borrow.
- o_dato_a  out  NB_DATA  registered operand A to the ALU.
- o_dato_b  out  NB_DATA  registered operand B to the ALU.
- o_op  out  NB_OP  registered opcode to the ALU.
- o_tx_data  out  NB_DATA  byte to transmit; held stable from o_tx_start until i_tx_done.
- o_tx_start  out  1  one-cycle start pulse to UART TX.
- o_busy  out  1  high in every state except GET_A.

Behaviour:
- Reset is synchronous, active-low, single clock i_clk. While i_rst_n=0 at a rising edge:
  - state <= GET_A
  - o_dato_a, o_dato_b, o_tx_data <= 0; o_op <= 0
  - o_tx_start <= 0; o_busy <= 0
  - carry register <= 0
- Reset applied mid-operation (any state) aborts the command; the partial command is discarded and no TX pulse is issued.
- States:
  - GET_A: on i_rx_done, o_dato_a <= i_rx_data -> GET_B.
  - GET_B: on i_rx_done, o_dato_b <= i_rx_data -> GET_OP.
  - GET_OP: on i_rx_done, o_op <= i_rx_data[NB_OP-1:0] (upper bits discarded) -> EXEC.
  - EXEC: one cycle for the ALU to settle; at the edge, o_tx_data <= i_alu_res, carry register <= i_alu_carry, o_tx_start <= 1 -> WAIT_TX.
  - WAIT_TX: o_tx_start is 0 from the second cycle on. On i_tx_done -> GET_A, or -> CARRY_TX when CARRY_BYTE_EN is defined.
- Latency: if i_rx_done for the opcode byte is sampled at edge N, o_op updates at N; o_tx_start is high during the cycle after edge N+1; o_tx_data is valid at that point.
- Operands stay registered after completion, so o_dato_a/o_dato_b/o_op keep the last command until overwritten.
- No arithmetic is performed here. Result and carry are captured unmodified; width is NB_DATA, no extension.
- Boundary conditions:
  - i_rx_done in EXEC, WAIT_TX or CARRY_TX: byte dropped, no state change. The host must wait for the result before sending the next command.
  - i_tx_done outside WAIT_TX/CARRY_TX: ignored.
  - i_rx_done and i_tx_done in the same cycle in WAIT_TX: the tx_done transition is taken; the rx byte is dropped.
  - Unknown opcode: forwarded as-is. The ALU returns 0 and carry 0, and 0x00 is transmitted.
  - Back-to-back commands: a byte strobed in the first cycle after returning to GET_A is accepted as operand A.

Optional Feature:
- Macro: ALU_UART_IFACE_CARRY_BYTE_EN.
- Defined:
  - After the result byte's i_tx_done, go to CARRY_TX.
  - CARRY_TX: o_tx_data <= {{NB_DATA-1{1'b0}}, carry}, one-cycle o_tx_start, wait for i_tx_done -> GET_A.
  - Two bytes are sent per command.
- Undefined: the CARRY_TX state and carry register are not built; the carry is not reported; one byte is sent per command.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, SRA=6'b000011, SRL=6'b000010, NOR=6'b100111
  - state encoding constants for GET_A, GET_B, GET_OP, EXEC, WAIT_TX, CARRY_TX
  - default widths NB_DATA=8, NB_OP=6
- No sub-module: the ALU is instantiated beside this block in the top level, not inside it.

Test Plan:
- RX 0x05, 0x03, 0x20 (ADD) -> o_dato_a=0x05, o_dato_b=0x03, o_op=6'h20; one o_tx_start pulse with o_tx_data=0x08 exactly 2 edges after the opcode strobe; after i_tx_done, o_busy=0.
- RX 0x03, 0x05, 0x22 (SUB) with macro defined -> first byte 0xFE, second byte 0x01 (borrow), each with its own o_tx_start; return to GET_A only after the second i_tx_done.
- RX 0xF0, 0x0F, 0xE7 (upper bits set, low bits NOR) -> o_op=6'h27, o_tx_data=0x00.
- During WAIT_TX, inject i_rx_done with 0xAA -> byte dropped; o_dato_a unchanged; the next command is decoded correctly.
- i_rst_n=0 for one edge while in GET_OP after A=0x11, B=0x22 -> all outputs 0, state GET_A, no o_tx_start; the following command 0x01, 0x01, 0x25 (OR) yields 0x01.
- i_tx_done pulsed in GET_A, then a same-cycle i_rx_done+i_tx_done in WAIT_TX -> no spurious transitions; the tx_done wins and the rx byte is dropped.
